mem_handshake_ctrl: RTL and testbench

//  Sequences RAM accesses requested by the microprogrammed control unit. Takes MOV/RW plus size from the

---
 rtl/mem_handshake_ctrl_pkg.sv | 33 +++
 rtl/mem_handshake_ctrl_if.sv | 34 +++
 rtl/mem_handshake_ctrl_lane_align.sv | 63 ++++++
 rtl/mem_handshake_ctrl.sv | 143 ++++++++++++++
 tb/tb_mem_handshake_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_handshake_ctrl_pkg.sv
// Shared definitions for the memory handshake controller.
//   size_e  : access size encoding carried in the control register
//   state_e : sequencing FSM states
//   ext_lane: right-justified lane value -> 32-bit sign/zero-extended word
package mem_handshake_ctrl_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_e;

  // Wide enough for WAIT_STATES up to 15.
  localparam int CNT_W = 4;

  // v holds the selected lane(s) right-justified; a byte lives in v[7:0].
  function automatic logic [31:0] ext_lane(input logic [15:0] v,
                                           input logic        is_half,
                                           input logic        sext);
    if (is_half) begin
      return sext ? {{16{v[15]}}, v} : {16'h0000, v};
    end
    return sext ? {{24{v[7]}}, v[7:0]} : {24'h000000, v[7:0]};
  endfunction

endpackage

// File: rtl/mem_handshake_ctrl_if.sv
// Bus bundle between the control unit, the handshake controller and the RAM.
//   Control side : mov, rw, size, sign_ext, addr, wdata -> moc, misalign, rdata
//   RAM side     : mem_en, mem_we, mem_be, mem_addr, mem_wdata -> mem_rdata
// modport slave  : the controller (mem_handshake_ctrl)
// modport master : the environment driving requests and modelling the RAM
interface mem_handshake_ctrl_if #(parameter int ADDR_W = 9);

  logic              mov;
  logic              rw;
  logic [1:0]        size;
  logic              sign_ext;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              moc;
  logic              misalign;
  logic [31:0]       rdata;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  mov, rw, size, sign_ext, addr, wdata, mem_rdata,
    output moc, misalign, rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output mov, rw, size, sign_ext, addr, wdata, mem_rdata,
    input  moc, misalign, rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_handshake_ctrl_lane_align.sv
// Combinational byte-lane logic for a big-endian 32-bit RAM.
//   size_i, off_i, sign_ext_i : access descriptor (off_i = addr[1:0])
//   wdata_i                   : right-justified store data
//   mem_rdata_i               : raw RAM word
//   be_o                      : lane strobes, be_o[3] = bits 31:24 = lowest address
//   lane_wdata_o              : store data replicated into every candidate lane
//   aligned_rdata_o           : selected lane(s) right-justified and extended
//   misalign_o                : alignment violation or reserved size
module mem_handshake_ctrl_lane_align
  import mem_handshake_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        sign_ext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] lane_wdata_o,
  output logic [31:0] aligned_rdata_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = mem_rdata_i[31:24];
      2'd1:    byte_sel = mem_rdata_i[23:16];
      2'd2:    byte_sel = mem_rdata_i[15:8];
      default: byte_sel = mem_rdata_i[7:0];
    endcase
    half_sel = off_i[1] ? mem_rdata_i[15:0] : mem_rdata_i[31:16];
  end

  always_comb begin
    be_o            = 4'b0000;
    lane_wdata_o    = wdata_i;
    aligned_rdata_o = mem_rdata_i;
    misalign_o      = 1'b0;
    case (size_i)
      SIZE_BYTE: begin
        be_o            = 4'b1000 >> off_i;
        lane_wdata_o    = {4{wdata_i[7:0]}};
        aligned_rdata_o = ext_lane({8'h00, byte_sel}, 1'b0, sign_ext_i);
      end
      SIZE_HALF: begin
        misalign_o      = off_i[0];
        be_o            = off_i[1] ? 4'b0011 : 4'b1100;
        lane_wdata_o    = {2{wdata_i[15:0]}};
        aligned_rdata_o = ext_lane(half_sel, 1'b1, sign_ext_i);
      end
      SIZE_WORD: begin
        misalign_o = |off_i;
        be_o       = 4'b1111;
      end
      default: begin
        misalign_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_handshake_ctrl.sv
// RAM access sequencer for the microprogrammed control unit.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : control-unit request/acknowledge plus RAM port (slave modport)
// Every output is a register; RAM strobes are held for WAIT_STATES+1 cycles.
//
//   state  | meaning
//   IDLE   | waiting for mov; latches the request descriptor
//   ACCESS | RAM strobes held while the wait counter runs down to 0
//   DONE   | moc asserted until mov is seen low
module mem_handshake_ctrl
  import mem_handshake_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input logic               clk,
  input logic               reset,
  mem_handshake_ctrl_if.slave bus
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rw_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic              sext_q;
  logic              moc_q;
  logic              misalign_q;
  logic [31:0]       rdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [3:0]        mem_be_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;

  logic        idle;
  logic [1:0]  size_sel;
  logic [1:0]  off_sel;
  logic        sext_sel;
  logic [3:0]  be;
  logic [31:0] lane_wdata;
  logic [31:0] aligned_rdata;
  logic        misalign;

  // Address bits above the RAM size wrap and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:ADDR_W];

  // In IDLE the lane logic decodes the live request; afterwards it works on
  // the latched descriptor so later input changes cannot disturb the access.
  assign idle     = (state_q == IDLE);
  assign size_sel = idle ? bus.size      : size_q;
  assign off_sel  = idle ? bus.addr[1:0] : off_q;
  assign sext_sel = idle ? bus.sign_ext  : sext_q;

  mem_handshake_ctrl_lane_align u_lane_align (
    .size_i          (size_sel),
    .off_i           (off_sel),
    .sign_ext_i      (sext_sel),
    .wdata_i         (bus.wdata),
    .mem_rdata_i     (bus.mem_rdata),
    .be_o            (be),
    .lane_wdata_o    (lane_wdata),
    .aligned_rdata_o (aligned_rdata),
    .misalign_o      (misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      sext_q      <= 1'b0;
      moc_q       <= 1'b0;
      misalign_q  <= 1'b0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.mov) begin
            rw_q   <= bus.rw;
            size_q <= bus.size;
            off_q  <= bus.addr[1:0];
            sext_q <= bus.sign_ext;
            if (misalign) begin
              // Rejected accesses never touch the RAM.
              misalign_q <= 1'b1;
              moc_q      <= 1'b1;
              state_q    <= DONE;
            end else begin
              cnt_q       <= CNT_W'(WAIT_STATES);
              mem_en_q    <= 1'b1;
              mem_we_q    <= ~bus.rw;
              mem_be_q    <= be;
              mem_addr_q  <= {bus.addr[ADDR_W-1:2], 2'b00};
              mem_wdata_q <= lane_wdata;
              state_q     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            if (rw_q) begin
              rdata_q <= aligned_rdata;
            end
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            mem_be_q <= 4'b0000;
            moc_q    <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (!bus.mov) begin
            moc_q      <= 1'b0;
            misalign_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.moc       = moc_q;
  assign bus.misalign  = misalign_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_handshake_ctrl.sv
// Bench for mem_handshake_ctrl: directed scenarios plus randomized accesses
// checked against a byte-addressed big-endian memory model.
module tb_mem_handshake_ctrl;

  localparam int ADDR_W = 9;
  localparam int WS     = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_handshake_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mem_handshake_ctrl #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // RAM responder: synchronous write on enabled edges, read word visible while enabled.
  logic [31:0] ram [128];
  logic        ld_en;
  logic [6:0]  ld_idx;
  logic [31:0] ld_val;

  always @(posedge clk) begin
    if (ld_en) begin
      ram[ld_idx] <= ld_val;
    end else if (bus.mem_en && bus.mem_we) begin
      for (int i = 0; i < 4; i++)
        if (bus.mem_be[i]) ram[bus.mem_addr[8:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    end
  end
  assign bus.mem_rdata = bus.mem_en ? ram[bus.mem_addr[8:2]] : 32'h0;

  // Reference model: memory as bytes, lowest address in the most significant lane.
  logic [31:0] ref_mem [128];
  logic [31:0] ref_rdata;

  function automatic int nb(input logic [1:0] sz);
    case (sz)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic exp_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || ((int'(a[1:0]) % nb(sz)) != 0);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    int sh;
    w  = ref_mem[a[8:2]];
    sh = 8 * (3 - int'(a[1:0]));
    return 8'(w >> sh);
  endfunction

  function automatic logic [31:0] exp_read(input logic [1:0] sz, input logic sx, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nb(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, ref_byte(32'(a + 32'(i)))};
    if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] m;
    m = 4'b0000;
    for (int i = 0; i < nb(sz); i++) m[3 - (int'(a[1:0]) + i)] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] exp_mwd(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] lo8, lo16;
    lo8  = wd & 32'h0000_00FF;
    lo16 = wd & 32'h0000_FFFF;
    if (nb(sz) == 1) return lo8 * 32'h0101_0101;
    if (nb(sz) == 2) return lo16 * 32'h0001_0001;
    return wd;
  endfunction

  task automatic ref_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = nb(sz);
    for (int i = 0; i < n; i++) begin
      logic [31:0] b;
      logic [7:0]  d;
      b = 32'(a + 32'(i));
      d = 8'(wd >> (8 * (n - 1 - i)));
      ref_mem[b[8:2]][8*(3 - int'(b[1:0])) +: 8] = d;
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    ld_en  = 1'b1;
    ld_idx = 7'(idx);
    ld_val = val;
    @(negedge clk);
    ld_en  = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Observations from the most recent transaction.
  int          o_lat, o_en;
  logic [3:0]  o_be;
  logic [8:0]  o_ma;
  logic [31:0] o_mwd, o_rd;
  logic        o_we, o_mis, o_steady, o_clr;

  task automatic run_txn(input logic rw_v, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input int hold);
    @(negedge clk);
    bus.rw = rw_v; bus.size = sz; bus.sign_ext = sx; bus.addr = a; bus.wdata = wd;
    bus.mov = 1'b1;
    o_lat = -1; o_en = 0; o_steady = 1'b1;
    o_be = 4'h0; o_ma = 9'h0; o_mwd = 32'h0; o_we = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        // Request fields must be ignored once latched.
        bus.rw = 1'($urandom); bus.size = 2'($urandom); bus.sign_ext = 1'($urandom);
        bus.addr = $urandom; bus.wdata = $urandom;
      end
      if (bus.mem_en) begin
        if (o_en == 0) begin
          o_be = bus.mem_be; o_ma = bus.mem_addr; o_mwd = bus.mem_wdata; o_we = bus.mem_we;
        end else if (o_be !== bus.mem_be || o_ma !== bus.mem_addr ||
                     o_mwd !== bus.mem_wdata || o_we !== bus.mem_we) begin
          o_steady = 1'b0;
        end
        o_en++;
      end
      if (bus.moc) begin
        o_lat = k;
        break;
      end
    end
    o_mis = bus.misalign;
    o_rd  = bus.rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (!bus.moc) o_steady = 1'b0;
    end
    bus.mov = 1'b0;
    @(posedge clk); #1;
    o_clr = !bus.moc && !bus.misalign;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.moc, bus.misalign, bus.mem_en, bus.mem_we} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: moc/mis/en/we=%b expected 0000",
               {bus.moc, bus.misalign, bus.mem_en, bus.mem_we});
    end
    tests_run++;
    if (bus.rdata !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data: rdata=%h mem_wdata=%h expected 0", bus.rdata, bus.mem_wdata);
    end
    tests_run++;
    if (bus.mem_be !== 4'h0 || bus.mem_addr !== 9'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: be=%b addr=%h expected 0", bus.mem_be, bus.mem_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    ref_rdata = 32'h0;
  endtask

  task automatic test_word_read();
    poke(4, 32'hDEAD_BEEF);
    run_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    tests_run++;
    if (o_lat !== WS + 2 || o_en !== WS + 1) begin
      tests_failed++;
      $display("FAIL word_read_timing: lat=%0d en_cycles=%0d expected %0d/%0d", o_lat, o_en, WS+2, WS+1);
    end
    tests_run++;
    if (o_be !== 4'b1111 || o_ma !== 9'h010 || o_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL word_read_bus: be=%b addr=%h we=%b expected 1111/010/0", o_be, o_ma, o_we);
    end
    tests_run++;
    if (o_rd !== 32'hDEAD_BEEF || o_clr !== 1'b1) begin
      tests_failed++;
      $display("FAIL word_read_data: rdata=%h clr=%b expected deadbeef/1", o_rd, o_clr);
    end
    ref_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic test_byte_read();
    poke(4, 32'h1234_56F0);
    run_txn(1'b1, 2'b00, 1'b1, 32'h13, 32'h0, 0);
    tests_run++;
    if (o_be !== 4'b0001 || o_rd !== 32'hFFFF_FFF0) begin
      tests_failed++;
      $display("FAIL byte_read_sext: be=%b rdata=%h expected 0001/fffffff0", o_be, o_rd);
    end
    run_txn(1'b1, 2'b00, 1'b0, 32'h13, 32'h0, 0);
    tests_run++;
    if (o_rd !== 32'h0000_00F0) begin
      tests_failed++;
      $display("FAIL byte_read_zext: rdata=%h expected 000000f0", o_rd);
    end
    ref_rdata = 32'h0000_00F0;
  endtask

  task automatic test_half_write();
    poke(8, 32'h1122_3344);
    run_txn(1'b0, 2'b01, 1'b0, 32'h22, 32'h0000_ABCD, 0);
    ref_write(2'b01, 32'h22, 32'h0000_ABCD);
    tests_run++;
    if (o_we !== 1'b1 || o_be !== 4'b0011 || o_mwd !== 32'hABCD_ABCD) begin
      tests_failed++;
      $display("FAIL half_write_bus: we=%b be=%b wdata=%h expected 1/0011/abcdabcd", o_we, o_be, o_mwd);
    end
    tests_run++;
    if (o_rd !== ref_rdata || o_steady !== 1'b1) begin
      tests_failed++;
      $display("FAIL half_write_hold: rdata=%h steady=%b expected %h/1", o_rd, o_steady, ref_rdata);
    end
    run_txn(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 0);
    tests_run++;
    if (o_rd[15:0] !== 16'hABCD || o_rd !== 32'h1122_ABCD) begin
      tests_failed++;
      $display("FAIL half_readback: rdata=%h expected 1122abcd", o_rd);
    end
    ref_rdata = 32'h1122_ABCD;
  endtask

  task automatic test_misaligned();
    run_txn(1'b1, 2'b10, 1'b0, 32'h06, 32'h0, 0);
    tests_run++;
    if (o_lat !== 1 || o_en !== 0 || o_mis !== 1'b1) begin
      tests_failed++;
      $display("FAIL misaligned: lat=%0d en_cycles=%0d mis=%b expected 1/0/1", o_lat, o_en, o_mis);
    end
    tests_run++;
    if (o_clr !== 1'b1 || o_rd !== ref_rdata) begin
      tests_failed++;
      $display("FAIL misaligned_clear: clr=%b rdata=%h expected 1/%h", o_clr, o_rd, ref_rdata);
    end
  endtask

  task automatic test_handshake();
    int moc_cnt;
    logic [31:0] exp;
    run_txn(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 4);
    exp = exp_read(2'b10, 1'b0, 32'h40);
    tests_run++;
    if (o_steady !== 1'b1 || o_clr !== 1'b1 || o_rd !== exp) begin
      tests_failed++;
      $display("FAIL handshake_hold: steady=%b clr=%b rdata=%h expected 1/1/%h", o_steady, o_clr, o_rd, exp);
    end
    ref_rdata = exp;
    // Re-assert immediately after the DONE exit edge.
    bus.rw = 1'b1; bus.size = 2'b10; bus.sign_ext = 1'b0; bus.addr = 32'h44;
    bus.mov = 1'b1;
    tests_run++;
    if (bus.mem_en !== 1'b0 || bus.moc !== 1'b0) begin
      tests_failed++;
      $display("FAIL reassert_exit_edge: en=%b moc=%b expected 0/0", bus.mem_en, bus.moc);
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus.mem_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL reassert_start: en=%b expected 1", bus.mem_en);
    end
    // Drop mov mid-access: access completes, moc pulses once.
    bus.mov = 1'b0;
    moc_cnt = 0;
    exp = exp_read(2'b10, 1'b0, 32'h44);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus.moc) begin
        moc_cnt++;
        o_rd = bus.rdata;
      end
    end
    tests_run++;
    if (moc_cnt !== 1 || o_rd !== exp) begin
      tests_failed++;
      $display("FAIL mov_drop_access: moc_cycles=%0d rdata=%h expected 1/%h", moc_cnt, o_rd, exp);
    end
    ref_rdata = exp;
  endtask

  task automatic test_reset_abort();
    int moc_cnt;
    @(negedge clk);
    bus.rw = 1'b0; bus.size = 2'b10; bus.addr = 32'h30; bus.wdata = $urandom;
    bus.mov = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({bus.mem_en, bus.mem_we, bus.moc} !== 3'b000 || bus.mem_be !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_abort: en/we/moc=%b be=%b expected 000/0000",
               {bus.mem_en, bus.mem_we, bus.moc}, bus.mem_be);
    end
    reset = 1'b0;
    bus.mov = 1'b0;
    ref_rdata = 32'h0;
    moc_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.moc) moc_cnt++;
    end
    tests_run++;
    if (moc_cnt !== 0 || bus.rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_abort_moc: moc_cycles=%0d rdata=%h expected 0/0", moc_cnt, bus.rdata);
    end
    // The aborted write may have reached the RAM; resynchronise that word.
    poke(12, 32'hCAFE_F00D);
  endtask

  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      logic        rw_v, sx, mis;
      logic [1:0]  sz;
      logic [31:0] a, wd, exp_rd;
      rw_v = 1'($urandom);
      sz   = 2'($urandom_range(0, 3));
      sx   = 1'($urandom);
      a    = $urandom;
      wd   = $urandom;
      mis  = exp_mis(sz, a);
      if (rw_v && !mis) exp_rd = exp_read(sz, sx, a);
      else              exp_rd = ref_rdata;
      run_txn(rw_v, sz, sx, a, wd, $urandom_range(0, 2));
      if (!rw_v && !mis) ref_write(sz, a, wd);
      ref_rdata = exp_rd;
      tests_run++;
      if (o_lat !== (mis ? 1 : WS + 2) || o_en !== (mis ? 0 : WS + 1) ||
          o_mis !== mis || o_clr !== 1'b1 || o_steady !== 1'b1) begin
        tests_failed++;
        $display("FAIL rand_ctrl[%0d]: lat=%0d en=%0d mis=%b clr=%b steady=%b expected mis=%b",
                 t, o_lat, o_en, o_mis, o_clr, o_steady, mis);
      end
      tests_run++;
      if (o_rd !== exp_rd) begin
        tests_failed++;
        $display("FAIL rand_rdata[%0d]: rdata=%h expected %h (sz=%0d a=%h sx=%b rw=%b)",
                 t, o_rd, exp_rd, sz, a, sx, rw_v);
      end
      if (!mis) begin
        tests_run++;
        if (o_be !== exp_be(sz, a) || o_ma !== 9'(a & 32'h1FC) || o_we !== !rw_v ||
            (!rw_v && o_mwd !== exp_mwd(sz, wd))) begin
          tests_failed++;
          $display("FAIL rand_bus[%0d]: be=%b addr=%h we=%b wdata=%h expected be=%b addr=%h",
                   t, o_be, o_ma, o_we, o_mwd, exp_be(sz, a), 9'(a & 32'h1FC));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ld_en = 1'b0; ld_idx = 7'h0; ld_val = 32'h0;
    bus.mov = 1'b0; bus.rw = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0;
    ref_rdata = 32'h0;
    test_reset();
    for (int i = 0; i < 128; i++) poke(i, $urandom);
    test_word_read();
    test_byte_read();
    test_half_write();
    test_misaligned();
    test_handshake();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests_failed=%0d", tests_failed);
    $fatal(1, "watchdog");
  end

endmodule
